// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter.
//   uart_state_t  : frame sequencer states
//   baud_w()      : baud counter width for a given clocks-per-bit
//   frame_cycles(): clk cycles per frame, from start bit to last stop bit
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // $clog2(CLKS_PER_BIT), never narrower than one bit.
  function automatic int baud_w(input int cpb);
    return (cpb <= 2) ? 1 : $clog2(cpb);
  endfunction

  function automatic int frame_cycles(input int width, input int parity_en,
                                      input int stop_bits, input int cpb);
    return (1 + width + parity_en + stop_bits) * cpb;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps explicitly.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : restart the count at 0 (asserted on byte accept)
//   bit_end    : high during the final cycle of each bit period
//   bit_pre    : high during the cycle before bit_end, so the parent can
//                register a pulse that lines up with bit_end
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end,
  output logic bit_pre
);

  localparam int BAUD_W = baud_w(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] PRE  = BAUD_W'(CLKS_PER_BIT - 2);

  logic [BAUD_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign bit_end = (cnt == LAST);
  assign bit_pre = (cnt == PRE);

endmodule

// File: rtl/uart_tx_stream.sv
// UART transmitter fed by a valid/ready byte stream (fifo output side).
// Frame: start(0), WIDTH data bits LSB first, optional parity, STOP_BITS
// stop bits(1). in_ready is only high while idle, so one byte is in
// flight at a time.
//   clk, rst_n   : clock, synchronous active-low reset
//   in_valid     : byte available
//   in_data      : byte to send
//   in_ready     : block can accept a byte
//   tx           : serial line, idles high
//   busy         : frame in flight
//   frame_done   : one-cycle pulse in the last stop-bit cycle
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int IDX_W = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WIDTH - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             ODD       = (PARITY_ODD != 0);

  uart_state_t      state;
  logic [WIDTH-1:0] shift;
  logic [IDX_W-1:0] bit_idx;
  logic             stop_cnt;
  logic             par;
  logic             accept;
  logic             bit_end;
  logic             bit_pre;

  assign accept = (state == IDLE) && in_valid && in_ready;

  // Restarting the counter on accept makes every bit period, including
  // the start bit, exactly CLKS_PER_BIT cycles.
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .bit_end (bit_end),
    .bit_pre (bit_pre)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift      <= '0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
      par        <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (accept) begin
            shift    <= in_data;
            par      <= (^in_data) ^ ODD;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            state    <= START;
          end else begin
            in_ready <= 1'b1;
          end
        end
        START: if (bit_end) begin
          tx    <= shift[0];
          shift <= shift >> 1;
          state <= DATA;
        end
        DATA: if (bit_end) begin
          if (bit_idx == IDX_LAST) begin
            bit_idx <= '0;
            if (PARITY_EN != 0) begin
              tx    <= par;
              state <= PARITY;
            end else begin
              tx    <= 1'b1;
              state <= STOP;
            end
          end else begin
            bit_idx <= bit_idx + 1'b1;
            tx      <= shift[0];
            shift   <= shift >> 1;
          end
        end
        PARITY: if (bit_end) begin
          tx    <= 1'b1;
          state <= STOP;
        end
        STOP: begin
          // Registered one cycle early so the pulse sits in the last cycle.
          if (bit_pre && stop_cnt == STOP_LAST) frame_done <= 1'b1;
          if (bit_end) begin
            if (stop_cnt == STOP_LAST) begin
              stop_cnt <= 1'b0;
              busy     <= 1'b0;
              in_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
module tb_uart_tx_stream;
  import uart_pkg::*;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_valid = '0;
  logic [7:0] in_data [4];
  logic [3:0] in_ready, tx, busy, fd;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // 0: plain, 1: even parity, 2: odd parity, 3: two stop bits
  uart_tx_stream #(.WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(fd[0]));
  uart_tx_stream #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut_pe (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(fd[1]));
  uart_tx_stream #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut_po (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_data(in_data[2]),
    .in_ready(in_ready[2]), .tx(tx[2]), .busy(busy[2]), .frame_done(fd[2]));
  uart_tx_stream #(.WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_data(in_data[3]),
    .in_ready(in_ready[3]), .tx(tx[3]), .busy(busy[3]), .frame_done(fd[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one byte on DUT d and samples the line mid-bit for F+3 cycles.
  // n counts cycles after the accept edge (n=1 is the first start-bit cycle).
  task automatic run_frame(input int d, input logic [7:0] b, input int f,
                           output logic [10:0] bits, output int fd_n,
                           output int rdy_n, output int fd_cnt,
                           output logic busy1, output logic busy_f);
    @(negedge clk);
    chk("ready_before_send", 32'(in_ready[d]), 32'd1);
    in_valid[d] = 1'b1;
    in_data[d]  = b;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    in_data[d]  = ~b;
    bits = '1; fd_n = -1; rdy_n = -1; fd_cnt = 0; busy1 = 1'b0; busy_f = 1'b0;
    for (int n = 1; n <= f + 3; n++) begin
      @(negedge clk);
      if ((n % CPB) == 2 && (n / CPB) < 11) bits[n / CPB] = tx[d];
      if (fd[d]) begin
        fd_cnt++;
        if (fd_n < 0) fd_n = n;
      end
      if (in_ready[d] && rdy_n < 0) rdy_n = n;
      if (n == 1) busy1 = busy[d];
      if (n == f) busy_f = busy[d];
    end
  endtask

  logic [10:0] bits;
  int          fd_n, rdy_n, fd_cnt, f;
  logic        b1, bf;
  logic [7:0]  q[$];
  logic        txlog [0:127];
  int          acc [2];
  int          nacc;
  logic [7:0]  rx;
  int          lows, pulses;

  initial begin
    for (int d = 0; d < 4; d++) in_data[d] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk("rst_tx", 32'(tx[d]), 32'd1);
      chk("rst_busy", 32'(busy[d]), 32'd0);
      chk("rst_ready", 32'(in_ready[d]), 32'd0);
      chk("rst_fd", 32'(fd[d]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(in_ready[0]), 32'd1);

    // Idle with no valid: line high, no pulses
    lows = 0; pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!tx[0]) lows++;
      if (fd[0]) pulses++;
    end
    chk("idle_tx_low_cycles", 32'(lows), 32'd0);
    chk("idle_fd_pulses", 32'(pulses), 32'd0);

    // 0xA5, no parity, one stop bit
    f = frame_cycles(8, 0, 1, CPB);
    chk("f_plain", 32'(f), 32'd40);
    run_frame(0, 8'hA5, f, bits, fd_n, rdy_n, fd_cnt, b1, bf);
    chk("a5_bits", 32'(bits), 32'({2'b11, 8'hA5, 1'b0}));
    chk("a5_fd_cycle", 32'(fd_n), 32'd40);
    chk("a5_fd_count", 32'(fd_cnt), 32'd1);
    chk("a5_ready_cycle", 32'(rdy_n), 32'd41);
    chk("a5_busy_first", 32'(b1), 32'd1);
    chk("a5_busy_last", 32'(bf), 32'd1);

    // Even parity: A5 has four ones, parity bit 0
    f = frame_cycles(8, 1, 1, CPB);
    run_frame(1, 8'hA5, f, bits, fd_n, rdy_n, fd_cnt, b1, bf);
    chk("even_bits", 32'(bits), 32'({1'b1, 1'b0, 8'hA5, 1'b0}));
    chk("even_fd_cycle", 32'(fd_n), 32'd44);

    // Odd parity: parity bit 1, F=44
    run_frame(2, 8'hA5, f, bits, fd_n, rdy_n, fd_cnt, b1, bf);
    chk("odd_bits", 32'(bits), 32'({1'b1, 1'b1, 8'hA5, 1'b0}));
    chk("odd_fd_cycle", 32'(fd_n), 32'd44);
    chk("odd_ready_cycle", 32'(rdy_n), 32'd45);

    // Two stop bits, 0x3C
    f = frame_cycles(8, 0, 2, CPB);
    run_frame(3, 8'h3C, f, bits, fd_n, rdy_n, fd_cnt, b1, bf);
    chk("stop2_bits", 32'(bits), 32'({2'b11, 8'h3C, 1'b0}));
    chk("stop2_fd_cycle", 32'(fd_n), 32'd44);
    chk("stop2_ready_cycle", 32'(rdy_n), 32'd45);

    // Fifo model in front: push 0x00 then 0xFF, out_ready = in_ready
    q = '{8'h00, 8'hFF};
    nacc = 0;
    for (int c = 0; c < 128; c++) begin
      @(negedge clk);
      txlog[c] = tx[0];
      in_valid[0] = (q.size() != 0);
      in_data[0]  = (q.size() != 0) ? q[0] : 8'h00;
      if (in_valid[0] && in_ready[0]) begin
        if (nacc < 2) acc[nacc] = c;
        nacc++;
        void'(q.pop_front());
      end
    end
    in_valid[0] = 1'b0;
    chk("fifo_accepts", 32'(nacc), 32'd2);
    chk("fifo_empty", 32'(q.size()), 32'd0);
    if (nacc == 2) begin
      chk("fifo_spacing", 32'(acc[1] - acc[0]), 32'd41);
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 8; i++) rx[i] = txlog[acc[k] + CPB * (i + 1) + 2];
        chk("fifo_start", 32'(txlog[acc[k] + 2]), 32'd0);
        chk("fifo_stop", 32'(txlog[acc[k] + CPB * 9 + 2]), 32'd1);
        chk("fifo_data", 32'(rx), (k == 0) ? 32'h00 : 32'hFF);
      end
    end

    // Reset in the middle of DATA
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h5A;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_tx", 32'(tx[0]), 32'd1);
    chk("midrst_busy", 32'(busy[0]), 32'd0);
    chk("midrst_ready", 32'(in_ready[0]), 32'd0);
    chk("midrst_fd", 32'(fd[0]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_back", 32'(in_ready[0]), 32'd1);
    chk("midrst_tx_idle", 32'(tx[0]), 32'd1);
    f = frame_cycles(8, 0, 1, CPB);
    run_frame(0, 8'h81, f, bits, fd_n, rdy_n, fd_cnt, b1, bf);
    chk("after_rst_bits", 32'(bits), 32'({2'b11, 8'h81, 1'b0}));
    chk("after_rst_fd_cycle", 32'(fd_n), 32'd40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
